shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU shift datapath. Executes SLL/SRL/SRA, one bit per cycle, under a start/busy/done handshake.
- The shift amount comes from one of two sources:
  - the instruction shamt field, zero-extended;
  - the low bits of the rs register value (variable shifts).
- Sits beside the ALU. The pipeline control stalls on busy and captures result on done.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; counter is SHAMT_W bits, values 0..2^SHAMT_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE or DONE
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- amt_sel  input  1  0: use shamt, 1: use rs_val[SHAMT_W-1:0]
- shamt  input  SHAMT_W  instruction shift field
- rs_val  input  DATA_W  register source for variable shifts
- data_in  input  DATA_W  operand to shift (rt)
- busy  output  1  high while in SHIFT state
- done  output  1  one-cycle pulse, result valid
- result  output  DATA_W  shifted value, held until next accepted start or reset
- op_err  output  1  registered with done; high when op==11

Behaviour:
- Reset (rst_n low at edge):
  - state=IDLE; busy=0, done=0, op_err=0, result=0, counter=0.
  - Overrides all other inputs, including mid-SHIFT; an in-flight op is discarded with no done.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- Accept: at an edge with start=1 and state IDLE or DONE:
  - latch op;
  - data register <= data_in;
  - cnt <= amt_sel ? rs_val[SHAMT_W-1:0] : shamt (zero-extended into counter);
  - op_err <= (op==11).
  - Next state: SHIFT if cnt!=0 and op!=11, else DONE.
- SHIFT, each edge:
  - shift data register one position:
    - SLL: left, fill 0;
    - SRL: right, fill 0;
    - SRA: right, fill with bit DATA_W-1.
  - cnt <= cnt-1.
  - When cnt==1 at the edge, next state is DONE.
  - start ignored (no queueing).
- DONE: done=1 and result = data register for exactly this cycle. Next edge:
  - start=1: accept new op (back-to-back, no idle bubble);
  - otherwise: go to IDLE.
- Outputs:
  - busy = (state==SHIFT).
  - done = (state==DONE).
  - result register updates only on the DONE entry, stable otherwise.
- Latency: start sampled at edge k → done high during the cycle after edge k+N, where N = amount, N=0..31. N=0 gives done after edge k.
- op==11: no shifting; result = data_in unchanged; done after 1 cycle; op_err=1 alongside done.
- rs_val upper bits [DATA_W-1:SHAMT_W] are ignored (MIPS variable-shift semantics).
- Inputs other than start/rst_n are don't-care outside the accept edge.

Optional Feature:
- Macro SHIFT_RADIX4_EN.
- Defined: each SHIFT edge shifts by min(cnt,4) positions and cnt <= cnt-min(cnt,4). Next state is DONE when cnt<=4 at the edge. Latency = ceil(N/4)+1 cycles. Fill rules unchanged.
- Undefined: 1 bit per cycle as above.
- Handshake, op_err, and reset behaviour are identical in both builds.

Test Plan:
- Reset then SLL: data_in=0x0000_0001, shamt=4, amt_sel=0, start pulse → busy high 4 cycles, done pulse on 5th cycle, result=0x0000_0010. Radix-4 build: busy 1 cycle, done on 2nd.
- SRA: data_in=0x8000_0000, amt_sel=1, rs_val=0xFFFF_FFE1 (amount 1) → result=0xC000_0000 after 2 cycles. Repeat with amount 31 → 0xFFFF_FFFF.
- SRL zero amount: data_in=0xDEAD_BEEF, shamt=0 → no busy cycle, done next cycle, result=0xDEAD_BEEF, op_err=0.
- Reserved op=11, data_in=0x1234_5678, shamt=7 → done next cycle, result=0x1234_5678, op_err=1.
- Back-to-back and ignored start:
  - SLL 0x1 by 2, with start held during SHIFT → the extra start is ignored.
  - New start in the DONE cycle (SRL 0x100 by 8) → accepted with no IDLE gap; results 0x4 then 0x1.
- Reset mid-operation: SLL shamt=20, assert rst_n=0 on 5th busy cycle → next edge busy=0, done=0, result=0. No done pulse follows; the next start works normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle SLL/SRL/SRA sequencer with a start/busy/done handshake.
// Optional build macro SHIFT_RADIX4_EN: shift up to 4 positions per cycle instead of 1.
`timescale 1ns/1ps
module shift_seq_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               amt_sel,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  data_in,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               op_err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 op_err_q, op_err_d;

  logic [SHAMT_W-1:0]   amt;
  logic [SHAMT_W-1:0]   step;
  logic [DATA_W-1:0]    shifted;

  // Upper rs bits never select an amount (variable shifts use only the low bits).
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_val[DATA_W-1:SHAMT_W];

  assign amt = amt_sel ? rs_val[SHAMT_W-1:0] : shamt;

`ifdef SHIFT_RADIX4_EN
  localparam logic [SHAMT_W-1:0] MaxStep = SHAMT_W'(4);
  assign step = (cnt_q < MaxStep) ? cnt_q : MaxStep;
`else
  assign step = SHAMT_W'(1);
`endif

  // One shift step of the data register according to the latched op.
  always_comb begin
    shifted = data_q;
    case (op_q)
      OpSll:   shifted = data_q << step;
      OpSrl:   shifted = data_q >> step;
      OpSra:   shifted = DATA_W'($signed(data_q) >>> step);
      default: shifted = data_q;
    endcase
  end

  // Next-state logic: accept in IDLE/DONE, step in SHIFT, capture result on DONE entry.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    op_err_d = op_err_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          op_d     = op;
          data_d   = data_in;
          cnt_d    = amt;
          op_err_d = (op == OpRsv);
          if ((amt != '0) && (op != OpRsv)) begin
            state_d = StShift;
          end else begin
            state_d  = StDone;
            result_d = data_in;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        data_d = shifted;
        cnt_d  = cnt_q - step;
        // Remaining count fits in this step: the shifted value is final.
        if (cnt_q <= step) begin
          state_d  = StDone;
          result_d = shifted;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      data_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OpSll;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      op_err_q <= op_err_d;
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign op_err = op_err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: latency/result model plus directed literal checks.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        amt_sel;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        op_err;

  int n_pass;
  int n_total;

  shift_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .amt_sel (amt_sel),
    .shamt   (shamt),
    .rs_val  (rs_val),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .op_err  (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Busy cycles an op must spend shifting.
  function automatic int exp_busy(input logic [1:0] o, input int n);
    if (o == 2'b11) return 0;
`ifdef SHIFT_RADIX4_EN
    return (n + 3) / 4;
`else
    return n;
`endif
  endfunction

  function automatic logic [31:0] model_shift(input logic [1:0] o, input logic [31:0] d,
                                              input int n);
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return 32'($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  // Model: busy countdown, pending result and done flag derived from op/amount.
  int          m_left;
  bit          m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;
  bit          m_err;
  int          m_n;
  int          m_b;
  logic [31:0] m_r;

  initial begin
    m_left = 0;
    m_done = 0;
    m_res  = '0;
    m_pend = '0;
    m_err  = 0;
  end

  // Compare process: advance the model each edge, then check the DUT just after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_res  = '0;
      m_err  = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_res  = m_pend;
      end
    end else if (start) begin
      m_n   = amt_sel ? int'(rs_val[4:0]) : int'(shamt);
      m_r   = model_shift(op, data_in, m_n);
      m_err = (op == 2'b11);
      m_b   = exp_busy(op, m_n);
      if (m_b == 0) begin
        m_done = 1;
        m_res  = m_r;
      end else begin
        m_done = 0;
        m_left = m_b;
        m_pend = m_r;
      end
    end else begin
      m_done = 0;
    end
    #1;
    check("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("cyc_done", {31'd0, done}, {31'd0, m_done});
    check("cyc_result", result, m_res);
    if (m_done) check("cyc_op_err", {31'd0, op_err}, {31'd0, m_err});
  end

  task automatic launch(input logic [1:0] o, input logic as, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] d);
    op      = o;
    amt_sel = as;
    shamt   = sh;
    rs_val  = rs;
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Returns at the negedge where done is high, counting busy cycles seen on the way.
  task automatic wait_done(output int nb);
    bit got;
    got = 0;
    nb  = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic as,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] d,
                       input logic [31:0] exp_res, input logic exp_err, input int amount);
    int nb;
    launch(o, as, sh, rs, d);
    wait_done(nb);
    check({name, "_result"}, result, exp_res);
    check({name, "_op_err"}, {31'd0, op_err}, {31'd0, exp_err});
    check({name, "_busy_cycles"}, nb, exp_busy(o, amount));
    @(negedge clk);
  endtask

  int nb;
  int n_dones;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    amt_sel = 1'b0;
    shamt   = '0;
    rs_val  = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_op_err", {31'd0, op_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("sll4", 2'b00, 1'b0, 5'd4, 32'h0, 32'h0000_0001, 32'h0000_0010, 1'b0, 4);
    do_op("sra1", 2'b10, 1'b1, 5'd9, 32'hFFFF_FFE1, 32'h8000_0000, 32'hC000_0000, 1'b0, 1);
    do_op("sra31", 2'b10, 1'b1, 5'd0, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 31);
    do_op("srl0", 2'b01, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
    do_op("rsv", 2'b11, 1'b0, 5'd7, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b1, 7);

    // Start held through the first shift cycle must not queue a second op.
    op = 2'b00; amt_sel = 1'b0; shamt = 5'd2; data_in = 32'h1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    check("held_start_result", result, 32'h0000_0004);
    @(negedge clk);
    check("held_start_idle_busy", {31'd0, busy}, 32'd0);
    check("held_start_idle_done", {31'd0, done}, 32'd0);

    // Back-to-back: new start during DONE is accepted with no idle gap.
    launch(2'b00, 1'b0, 5'd2, 32'h0, 32'h1);
    wait_done(nb);
    check("b2b_first_result", result, 32'h0000_0004);
    launch(2'b01, 1'b0, 5'd8, 32'h0, 32'h100);
    check("b2b_no_gap_busy", {31'd0, busy}, {31'd0, exp_busy(2'b01, 8) > 0});
    wait_done(nb);
    check("b2b_second_result", result, 32'h0000_0001);
    check("b2b_second_busy", nb, exp_busy(2'b01, 8));
    @(negedge clk);

    // Reset on the 5th busy cycle discards the op.
    launch(2'b00, 1'b0, 5'd20, 32'h0, 32'h1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    rst_n = 1'b1;
    n_dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) n_dones++;
      @(negedge clk);
    end
    check("midrst_no_done", n_dones, 0);
    do_op("after_rst", 2'b00, 1'b0, 5'd1, 32'h0, 32'h3, 32'h0000_0006, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
